power_tap_monitor: RTL and testbench
====================================

Name: power_tap_monitor

Overview:
- Consumer end of the power-test counter bank. Samples the bank's NUM-bit tap vector and counts bit toggles over a fixed window of cycles.
- Reports each window total through a valid/ready result interface, so software or a host logger can confirm the load is really switching.
- Sits next to the counter bank in the power-test top. The per-bit XOR plus popcount adds measurable load of its own.

Parameters:
- NUM, 512: width of the taps input.
- WIN_LOG2, 10: window length is 2^WIN_LOG2 toggle samples; legal range 1..20.
- MIN_TOGGLES, 0: threshold; a window total strictly below it sets res_low.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run monitoring; level-sensitive.
- taps  in  NUM  tap vector, synchronous to clk.
- res_valid  out  1  window result available.
- res_ready  in  1  consumer accepts result.
- res_count  out  ACC_W  toggle total for the window; ACC_W = $clog2(NUM+1)+WIN_LOG2.
- res_low  out  1  res_count < MIN_TOGGLES.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock is clk. Reset is rst_n, synchronous, active-low.
- Reset values: state=IDLE; res_valid=0, res_count=0, res_low=0, busy=0; taps_q, accumulator, pipeline registers and window counter all 0.
- FSM states: IDLE, ARM, RUN, DRAIN, REPORT.
- IDLE: when enable=1, go to ARM.
- ARM (1 cycle): taps_q<=taps; accumulator<=0; window counter<=0; nothing is counted. Then go to RUN.
- RUN (exactly 2^WIN_LOG2 cycles):
  - Each cycle, push toggle vector (taps ^ taps_q) into the popcount pipeline, and set taps_q<=taps.
  - The first RUN cycle compares against the value captured in ARM.
  - After the last push, go to DRAIN.
- Popcount pipeline, fixed 2 stages:
  - Stage 1: per-32-bit-chunk partial sums (last chunk zero-padded when NUM is not a multiple of 32).
  - Stage 2: sum of the chunk sums.
  - Stage-2 output adds into the accumulator one cycle later.
  - Total latency from a push to its accumulator update is 3 cycles.
  - Each pipeline stage carries a valid bit; only valid entries accumulate.
- DRAIN: wait until all pipeline valid bits are 0 and the last add has been committed. Then register res_count<=accumulator and res_low<=(accumulator<MIN_TOGGLES), and go to REPORT.
- REPORT:
  - res_valid=1; res_count and res_low held stable until res_valid && res_ready.
  - On that handshake cycle: res_valid<=0, then go to ARM if enable=1, else IDLE.
  - No new window is sampled while in REPORT. Toggles during backpressure are deliberately not counted.
- enable=0 in ARM, RUN or DRAIN: abort on the next edge. Go to IDLE, clear the pipeline valid bits and the accumulator; no result is produced.
- enable=0 in REPORT: the result is still held until accepted, then go to IDLE.
- Width rule: ACC_W holds NUM*2^WIN_LOG2 exactly, so the accumulator never wraps. Window counter is WIN_LOG2+1 bits.
- res_ready high while res_valid=0 has no effect.
- Reset asserted mid-operation: every register returns to its reset value on that edge, and any pending result is lost.

Decomposition:
- Shared package power_test_pkg:
  - mon_state_e enum (IDLE, ARM, RUN, DRAIN, REPORT).
  - Function acc_width(num, win_log2).
  - Constant POPCNT_CHUNK=32.
  - Constant POPCNT_LAT=2.
- Sub-module popcount_pipe, parameterised by NUM:
  - Ports: clk, rst_n, flush, in_valid, in_vec, out_valid, out_cnt.
  - Contains the 2-stage adder tree.
  - Reused by future power-test monitors.

Test Plan:
- NUM=512, WIN_LOG2=4, taps held at 0, enable=1 -> after ARM+16 RUN+DRAIN: res_valid=1, res_count=0; res_low=1 when MIN_TOGGLES=1.
- taps alternating all-ones/all-zeros every cycle, NUM=512, WIN_LOG2=4 -> res_count=8192 (maximum; no wrap, checks ACC_W=14), res_low=0.
- Only taps[511] toggling every cycle; taps[3] changes once between ARM and the first RUN cycle -> res_count=17, which confirms the ARM capture and the top chunk boundary.
- Backpressure: res_ready=0 for 10 cycles after res_valid, taps toggling throughout -> res_valid and res_count stable for all 10 cycles, busy=1. After the handshake, the next window restarts via ARM and its count excludes the stalled cycles.
- Abort: enable dropped on RUN cycle 7 -> state returns to IDLE, res_valid never asserts. Re-enable -> the next result counts only the new window.
- Reset mid-DRAIN, and separately mid-REPORT -> the next cycle shows res_valid=0, res_count=0, busy=0; a following full window gives the correct count.

Source files
------------

// File: rtl/power_test_pkg.sv
// Shared types and helpers for the power-test monitor blocks.
package power_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } mon_state_e;

    localparam int POPCNT_CHUNK = 32;
    localparam int POPCNT_LAT   = 2;

    // Accumulator width able to hold num toggles per sample over 2^win_log2 samples.
    function automatic int acc_width(input int num, input int win_log2);
        return $clog2(num + 1) + win_log2;
    endfunction

endpackage

// File: rtl/popcount_pipe.sv
// Two-stage population count: per-chunk partial sums, then a sum of the chunk sums.
module popcount_pipe
    import power_test_pkg::*;
#(
    parameter  int NUM   = 512,
    localparam int OUT_W = $clog2(NUM + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [NUM-1:0]   in_vec,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_cnt
);

    localparam int NCHUNK = (NUM + POPCNT_CHUNK - 1) / POPCNT_CHUNK;
    localparam int PAD    = NCHUNK * POPCNT_CHUNK;
    localparam int CW     = $clog2(POPCNT_CHUNK + 1);

    logic [PAD-1:0]   vec_pad_s;
    logic [CW-1:0]    chunk_sum_s [NCHUNK];
    logic [CW-1:0]    chunk_q     [NCHUNK];
    logic             s1_valid_q;
    logic [OUT_W-1:0] total_s;
    logic [OUT_W-1:0] out_cnt_q;
    logic             s2_valid_q;

    // The top chunk is zero-padded so every chunk has the same width.
    assign vec_pad_s = PAD'(in_vec);

    // Stage-1 combinational chunk sums.
    always_comb begin
        for (int c = 0; c < NCHUNK; c++) begin
            chunk_sum_s[c] = '0;
            for (int b = 0; b < POPCNT_CHUNK; b++) begin
                chunk_sum_s[c] = chunk_sum_s[c] + CW'(vec_pad_s[c*POPCNT_CHUNK + b]);
            end
        end
    end

    // Stage-2 combinational sum of the registered chunk sums.
    always_comb begin
        total_s = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            total_s = total_s + OUT_W'(chunk_q[c]);
        end
    end

    // Pipeline registers; flush drops in-flight entries but leaves data alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHUNK; c++) begin
                chunk_q[c] <= '0;
            end
            s1_valid_q <= 1'b0;
            out_cnt_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCHUNK; c++) begin
                chunk_q[c] <= chunk_sum_s[c];
            end
            out_cnt_q  <= total_s;
            s1_valid_q <= flush ? 1'b0 : in_valid;
            s2_valid_q <= flush ? 1'b0 : s1_valid_q;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: rtl/power_tap_monitor.sv
// Counts tap-vector bit toggles over a fixed window and reports each total via valid/ready.
module power_tap_monitor
    import power_test_pkg::*;
#(
    parameter  int          NUM         = 512,
    parameter  int          WIN_LOG2    = 10,
    parameter  int unsigned MIN_TOGGLES = 0,
    localparam int          ACC_W       = acc_width(NUM, WIN_LOG2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [NUM-1:0]   taps,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_count,
    output logic             res_low,
    output logic             busy
);

    localparam int WCW     = WIN_LOG2 + 1;
    localparam int WIN_LEN = 1 << WIN_LOG2;
    localparam int CNT_W   = $clog2(NUM + 1);

    mon_state_e             state_q, state_d;
    logic [NUM-1:0]         taps_q, taps_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WCW-1:0]         win_q, win_d;
    logic [POPCNT_LAT-1:0]  pend_q, pend_d;
    logic [ACC_W-1:0]       res_count_q, res_count_d;
    logic                   res_low_q, res_low_d;
    logic                   res_valid_q, busy_q;
    logic                   push_s, flush_s;
    logic                   pp_valid_s;
    logic [CNT_W-1:0]       pp_cnt_s;

    popcount_pipe #(.NUM(NUM)) u_popcount (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .in_valid  (push_s),
        .in_vec    (taps ^ taps_q),
        .out_valid (pp_valid_s),
        .out_cnt   (pp_cnt_s)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        win_d       = win_q;
        res_count_d = res_count_q;
        res_low_d   = res_low_q;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        acc_d       = pp_valid_s ? (acc_q + ACC_W'(pp_cnt_s)) : acc_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                    acc_d   = '0;
                end else begin
                    taps_d  = taps;
                    acc_d   = '0;
                    win_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                    acc_d   = '0;
                end else begin
                    push_s = 1'b1;
                    taps_d = taps;
                    win_d  = win_q + WCW'(1);
                    if (win_q == WCW'(WIN_LEN - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if (!enable) begin
                    state_d = IDLE;
                    flush_s = 1'b1;
                    acc_d   = '0;
                end else if (pend_q == '0) begin
                    // Both stages empty means the final add has already landed in acc_q.
                    res_count_d = acc_q;
                    res_low_d   = (64'(acc_q) < 64'(MIN_TOGGLES));
                    state_d     = REPORT;
                end else begin
                    state_d = DRAIN;
                end
            end
            REPORT: begin
                if (res_valid_q && res_ready) begin
                    state_d = enable ? ARM : IDLE;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pend_d = flush_s ? '0 : {pend_q[POPCNT_LAT-2:0], push_s};
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            acc_q       <= '0;
            win_q       <= '0;
            pend_q      <= '0;
            res_count_q <= '0;
            res_low_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
            pend_q      <= pend_d;
            res_count_q <= res_count_d;
            res_low_q   <= res_low_d;
            res_valid_q <= (state_d == REPORT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_low   = res_low_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_power_tap_monitor.sv
// Directed bench for power_tap_monitor with NUM=512, WIN_LOG2=4, MIN_TOGGLES=1.
module tb_power_tap_monitor;

    localparam int NUM   = 512;
    localparam int ACC_W = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [NUM-1:0]   taps;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_count;
    logic             res_low;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    power_tap_monitor #(.NUM(NUM), .WIN_LOG2(4), .MIN_TOGGLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .taps      (taps),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_low   (res_low),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // mode 0: zeros; 1: all-ones/all-zeros alternating; 2: bit511 toggles, bit3 rises at k=2; 3: hold.
    task automatic drive_taps(input int mode, input int k);
        case (mode)
            0: taps = '0;
            1: taps = k[0] ? '1 : '0;
            2: begin
                taps      = '0;
                taps[511] = k[0];
                taps[3]   = (k >= 2);
            end
            default: taps = taps;
        endcase
    endtask

    // Enable and drive until res_valid shows; k counts edges since enable was driven.
    task automatic run_window(input int mode, output int lat, output bit got);
        enable = 1'b1;
        drive_taps(mode, 0);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 80 && !got; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                got = 1'b1;
                lat = k;
            end else begin
                drive_taps(mode, k);
            end
        end
    endtask

    task automatic step_window(input int mode, input int nedges);
        enable = 1'b1;
        drive_taps(mode, 0);
        for (int k = 1; k <= nedges; k++) begin
            @(posedge clk); #1;
            drive_taps(mode, k);
        end
    endtask

    task automatic accept(input logic en_after);
        res_ready = 1'b1;
        enable    = en_after;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input bit got, input logic [ACC_W-1:0] exp_cnt,
                                input logic exp_low);
        n_tests++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: res_valid never rose, required within 80 cycles", name);
        end
        n_tests++;
        if (res_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_count: got %0d, required %0d", name, res_count, exp_cnt);
        end
        n_tests++;
        if (res_low !== exp_low) begin
            n_fail++;
            $display("FAIL %s_low: got %b, required %b", name, res_low, exp_low);
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if (res_valid !== 1'b0 || res_count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b count=%0d busy=%b, required 0/0/0", name, res_valid, res_count, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; res_ready = 1'b0; taps = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_state");
        n_tests++;
        if (res_low !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_low: got %b, required 0", res_low);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_window();
        int lat; bit got;
        run_window(0, lat, got);
        check_result("zero", got, 14'd0, 1'b1);
        n_tests++;
        if (lat !== 21) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles, required 21", lat);
        end
        accept(1'b0);
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_handshake: res_valid got %b, required 0", res_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_max_toggle();
        int lat; bit got;
        run_window(1, lat, got);
        check_result("max", got, 14'd8192, 1'b0);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_arm_capture();
        int lat; bit got;
        run_window(2, lat, got);
        check_result("arm_capture", got, 14'd17, 1'b0);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; bit got;
        run_window(1, lat, got);
        check_result("bp_first", got, 14'd8192, 1'b0);
        for (int i = 0; i < 10; i++) begin
            taps = ~taps;
            @(posedge clk); #1;
            n_tests++;
            if (res_valid !== 1'b1 || res_count !== 14'd8192 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b count=%0d busy=%b, required 1/8192/1",
                         i, res_valid, res_count, busy);
            end
        end
        accept(1'b1);
        run_window(3, lat, got);
        check_result("bp_next", got, 14'd0, 1'b1);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat; bit got; bit seen;
        step_window(1, 9);
        enable = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b, required 0", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_result: res_valid seen %b, required 0", seen);
        end
        run_window(2, lat, got);
        check_result("abort_rerun", got, 14'd17, 1'b0);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_drain();
        int lat; bit got;
        step_window(1, 19);
        rst_n = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        check_cleared("rst_drain_state");
        rst_n = 1'b1;
        run_window(1, lat, got);
        check_result("rst_drain_next", got, 14'd8192, 1'b0);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_report();
        int lat; bit got;
        run_window(1, lat, got);
        check_result("rst_report_pre", got, 14'd8192, 1'b0);
        rst_n = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        check_cleared("rst_report_state");
        rst_n = 1'b1;
        run_window(2, lat, got);
        check_result("rst_report_next", got, 14'd17, 1'b0);
        accept(1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_zero_window();
        test_max_toggle();
        test_arm_capture();
        test_backpressure();
        test_abort();
        test_reset_drain();
        test_reset_report();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
